// File: rtl/arbitro_paralelo_serial_pkg.sv
// Shared symbol values and FSM encoding for the PHY byte scheduler.
package ps_defs;

  localparam logic [7:0] COM      = 8'hBC;
  localparam logic [7:0] HDR_BASE = 8'hF0;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

endpackage

// File: rtl/arbitro_rr.sv
// Two-requester round-robin grant; the pointer moves past the source whose burst just ended.
module arbitro_rr (
  input  logic clk_4f,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  input  logic upd_gnt,
  output logic gnt,
  output logic any
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (upd) ptr_d = ~upd_gnt;
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

  // A lone requester wins outright; contention is settled by the pointer.
  assign gnt = (req0 && req1) ? ptr_q : req1;
  assign any = req0 | req1;

endmodule

// File: rtl/arbitro_paralelo_serial.sv
// Shares one parallel-to-serial converter between two byte sources: COM sync burst,
// then round-robin header-prefixed bursts with idle COM fill.
module arbitro_paralelo_serial
  import ps_defs::*;
#(
  parameter int SYNC_LEN  = 4,
  parameter int BURST_MAX = 4
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       valid0_in,
  input  logic [7:0] data0_in,
  input  logic       valid1_in,
  input  logic [7:0] data1_in,
  output logic       ready0_out,
  output logic       ready1_out,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       sync_done_out
);

  localparam int SW = $clog2(SYNC_LEN + 1);
  localparam int CW = $clog2(BURST_MAX + 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   sync_cnt_q, sync_cnt_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            gnt_q, gnt_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            sync_done_q, sync_done_d;

  logic            arb_gnt;
  logic            arb_any;
  logic            ptr_upd;
  logic            sel_valid;
  logic [7:0]      sel_data;
  logic            sync_end;
  logic            last_xfer;
  logic            can_grant;

  arbitro_rr u_rr (
    .clk_4f  (clk_4f),
    .reset   (reset),
    .req0    (valid0_in),
    .req1    (valid1_in),
    .upd     (ptr_upd),
    .upd_gnt (gnt_q),
    .gnt     (arb_gnt),
    .any     (arb_any)
  );

  assign sel_valid = gnt_q ? valid1_in : valid0_in;
  assign sel_data  = gnt_q ? data1_in  : data0_in;
  assign sync_end  = (sync_cnt_q == SW'(SYNC_LEN));
  assign last_xfer = (burst_cnt_q == CW'(BURST_MAX - 1));
  // Granting only while the output already shows idle guarantees a valid-low gap between bursts.
  assign can_grant = arb_any && !valid_q;

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SYNC;
      sync_cnt_q  <= '0;
      burst_cnt_q <= '0;
      gnt_q       <= 1'b0;
      data_q      <= COM;
      valid_q     <= 1'b0;
      sync_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      gnt_q       <= gnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sync_done_q <= sync_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:  if (sync_end) state_d = ST_IDLE;
      ST_IDLE:  if (can_grant) state_d = ST_BURST;
      ST_BURST: if (!sel_valid || last_xfer) state_d = ST_IDLE;
      default:  state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    data_d      = COM;
    valid_d     = 1'b0;
    sync_cnt_d  = sync_cnt_q;
    burst_cnt_d = burst_cnt_q;
    gnt_d       = gnt_q;
    sync_done_d = sync_done_q;
    ptr_upd     = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (sync_end) begin
          sync_done_d = 1'b1;
        end else begin
          valid_d    = 1'b1;
          sync_cnt_d = sync_cnt_q + SW'(1);
        end
      end
      ST_IDLE: begin
        if (can_grant) begin
          data_d      = HDR_BASE | {7'b0, arb_gnt};
          valid_d     = 1'b1;
          gnt_d       = arb_gnt;
          burst_cnt_d = '0;
        end
      end
      ST_BURST: begin
        if (sel_valid) begin
          data_d      = sel_data;
          valid_d     = 1'b1;
          burst_cnt_d = burst_cnt_q + CW'(1);
        end
        if (!sel_valid || last_xfer) ptr_upd = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ready0_out = (state_q == ST_BURST) && !gnt_q;
    ready1_out = (state_q == ST_BURST) &&  gnt_q;
  end

  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign sync_done_out = sync_done_q;

endmodule

// File: tb/tb_arbitro_paralelo_serial.sv
// Directed bench for the byte scheduler: per-cycle compare against a stream-level model,
// plus literal checks of the captured valid-byte stream.
module tb_arbitro_paralelo_serial;

  localparam int SYNC_LEN  = 4;
  localparam int BURST_MAX = 4;

  logic       clk_4f = 1'b0;
  logic       reset = 1'b0;
  logic       valid0_in = 1'b0;
  logic       valid1_in = 1'b0;
  logic [7:0] data0_in = 8'h00;
  logic [7:0] data1_in = 8'h00;
  logic       ready0_out;
  logic       ready1_out;
  logic [7:0] data_out;
  logic       valid_out;
  logic       sync_done_out;

  arbitro_paralelo_serial #(.SYNC_LEN(SYNC_LEN), .BURST_MAX(BURST_MAX)) dut (
    .clk_4f        (clk_4f),
    .reset         (reset),
    .valid0_in     (valid0_in),
    .data0_in      (data0_in),
    .valid1_in     (valid1_in),
    .data1_in      (data1_in),
    .ready0_out    (ready0_out),
    .ready1_out    (ready1_out),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .sync_done_out (sync_done_out)
  );

  always #5 clk_4f = ~clk_4f;

  int tests = 0;
  int fails = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] got_d[$];
  int         got_e[$];
  logic [7:0] exp_q[$];

  function automatic void chk(string n, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", n, act, exp, $time);
    end
  endfunction

  // Stream model: what must appear on the converter side, byte by byte.
  logic [7:0] m_data;
  logic       m_valid, m_done, m_burst, m_src, m_ptr;
  int         m_sync, m_cnt, edge_no;

  always @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      m_data = 8'hBC; m_valid = 1'b0; m_done = 1'b0; m_burst = 1'b0;
      m_src = 1'b0; m_ptr = 1'b0; m_sync = 0; m_cnt = 0; edge_no = 0;
    end else begin
      edge_no++;
      if (!m_done) begin
        m_data = 8'hBC;
        if (m_sync < SYNC_LEN) begin
          m_sync++;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
          m_done = 1'b1;
        end
      end else if (!m_burst) begin
        if (!m_valid && (valid0_in || valid1_in)) begin
          m_src   = (valid0_in && valid1_in) ? m_ptr : valid1_in;
          m_data  = {7'b1111000, m_src};
          m_valid = 1'b1;
          m_burst = 1'b1;
          m_cnt   = 0;
        end else begin
          m_data  = 8'hBC;
          m_valid = 1'b0;
        end
      end else begin
        if (m_src ? valid1_in : valid0_in) begin
          m_data  = m_src ? data1_in : data0_in;
          m_valid = 1'b1;
          m_cnt++;
          if (m_cnt == BURST_MAX) begin
            m_burst = 1'b0;
            m_ptr   = ~m_src;
          end
        end else begin
          m_data  = 8'hBC;
          m_valid = 1'b0;
          m_burst = 1'b0;
          m_ptr   = ~m_src;
        end
      end
    end
  end

  always @(negedge clk_4f) begin
    chk("data_out", int'(data_out), int'(m_data));
    chk("valid_out", int'(valid_out), int'(m_valid));
    chk("sync_done", int'(sync_done_out), int'(m_done));
    chk("ready0", int'(ready0_out), int'(m_burst && !m_src));
    chk("ready1", int'(ready1_out), int'(m_burst && m_src));
    if (valid_out && !reset) begin
      got_d.push_back(data_out);
      got_e.push_back(edge_no);
    end
  end

  task automatic apply();
    valid0_in = (q0.size() > 0);
    data0_in  = (q0.size() > 0) ? q0[0] : 8'h00;
    valid1_in = (q1.size() > 0);
    data1_in  = (q1.size() > 0) ? q1[0] : 8'h00;
  endtask

  task automatic step(output logic r0, output logic r1);
    @(negedge clk_4f);
    r0 = ready0_out;
    r1 = ready1_out;
    @(posedge clk_4f);
    #1;
    if (r0 && valid0_in) void'(q0.pop_front());
    if (r1 && valid1_in) void'(q1.pop_front());
    apply();
  endtask

  task automatic run(int n);
    logic a, b;
    repeat (n) step(a, b);
  endtask

  task automatic clear_got();
    got_d.delete();
    got_e.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk_4f);
    #1;
    reset = 1'b0;
    clear_got();
  endtask

  task automatic chk_seq(string n);
    chk({n, "_len"}, got_d.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_d.size(); i++)
      chk($sformatf("%s[%0d]", n, i), int'(got_d[i]), int'(exp_q[i]));
  endtask

  initial begin
    int   run_len, first_run;
    logic a, b, prev;

    #2 reset = 1'b1;
    #1;
    chk("rst_data", int'(data_out), 'hBC);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_sync_done", int'(sync_done_out), 0);
    chk("rst_ready0", int'(ready0_out), 0);
    chk("rst_ready1", int'(ready1_out), 0);
    repeat (3) @(posedge clk_4f);
    #1;
    reset = 1'b0;
    clear_got();

    // Sync burst with no requests.
    run(8);
    exp_q = '{8'hBC, 8'hBC, 8'hBC, 8'hBC};
    chk_seq("sync");
    chk("sync_first_edge", got_e.size() > 0 ? got_e[0] : -1, 1);
    chk("sync_last_edge", got_e.size() > 3 ? got_e[3] : -1, SYNC_LEN);
    chk("sync_done_held", int'(sync_done_out), 1);
    chk("idle_valid", int'(valid_out), 0);
    chk("idle_data", int'(data_out), 'hBC);

    // Source 0 alone, five bytes: full burst, idle gap, one-byte burst.
    clear_got();
    q0 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    apply();
    run_len = 0; first_run = -1; prev = 1'b0;
    repeat (14) begin
      step(a, b);
      if (a) run_len++;
      else if (prev && first_run < 0) first_run = run_len;
      prev = a;
    end
    exp_q = '{8'hF0, 8'h11, 8'h22, 8'h33, 8'h44, 8'hF0, 8'h55};
    chk_seq("src0");
    chk("src0_ready_run", first_run, 4);
    chk("src0_gap", (got_e.size() > 5) ? got_e[5] - got_e[4] : 0, 2);

    // Both sources continuously after a fresh reset: headers alternate.
    q0 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    q1 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
    apply();
    do_reset();
    run(40);
    exp_q = '{8'hBC, 8'hBC, 8'hBC, 8'hBC,
              8'hF0, 8'hA0, 8'hA1, 8'hA2, 8'hA3,
              8'hF1, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
              8'hF0, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
              8'hF1, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
    chk_seq("both");
    chk("both_hdr_edge", got_e.size() > 4 ? got_e[4] : -1, SYNC_LEN + 2);

    // Source 1 short burst, then contention hands the next grant to source 0.
    clear_got();
    q1 = '{8'hA5, 8'h5A};
    apply();
    run(6);
    chk("short_end_valid", int'(valid_out), 0);
    q0 = '{8'h01};
    q1 = '{8'h02};
    apply();
    run(12);
    exp_q = '{8'hF1, 8'hA5, 8'h5A, 8'hF0, 8'h01, 8'hF1, 8'h02};
    chk_seq("short");

    // Requests during sync, symbol-valued data, then reset mid-burst.
    q0 = '{8'hBC, 8'hF0, 8'hF1, 8'h33};
    q1 = '{8'h99};
    apply();
    do_reset();
    run(SYNC_LEN + 4);
    exp_q = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hF0, 8'hBC};
    chk_seq("sync_req");
    chk("sync_req_hdr_edge", got_e.size() > 4 ? got_e[4] : -1, SYNC_LEN + 2);
    chk("passthru_f0", int'(data_out), 'hF0);
    reset = 1'b1;
    #1;
    chk("mid_rst_data", int'(data_out), 'hBC);
    chk("mid_rst_valid", int'(valid_out), 0);
    chk("mid_rst_sync_done", int'(sync_done_out), 0);
    chk("mid_rst_ready0", int'(ready0_out), 0);
    chk("mid_rst_ready1", int'(ready1_out), 0);
    q0.delete();
    q1.delete();
    apply();
    repeat (2) @(posedge clk_4f);
    #1;
    reset = 1'b0;
    clear_got();
    run(SYNC_LEN);
    chk("resync_not_done", int'(sync_done_out), 0);
    run(4);
    exp_q = '{8'hBC, 8'hBC, 8'hBC, 8'hBC};
    chk_seq("resync");
    chk("resync_done", int'(sync_done_out), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
